// File: rtl/hamming_secded_pipe_if.sv
// rtl/hamming_secded_pipe_if.sv - beat handshake bundle for the SECDED encode/decode pipeline
interface hamming_secded_pipe_if #(
   parameter int CODED_WIDTH = 39,
   parameter int ADDR_WIDTH  = 6
);
   logic                   in_valid;
   logic                   in_ready;
   logic                   mode;
   logic [CODED_WIDTH-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [CODED_WIDTH-1:0] out_data;
   logic                   out_mode;
   logic                   out_single_err;
   logic                   out_double_err;
   logic [ADDR_WIDTH-1:0]  out_syndrome;

   modport master (
      output in_valid, mode, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_mode, out_single_err, out_double_err, out_syndrome
   );

   modport slave (
      input  in_valid, mode, in_data, out_ready,
      output in_ready, out_valid, out_data, out_mode, out_single_err, out_double_err, out_syndrome
   );
endinterface

// File: rtl/hamming_secded_pipe.sv
// rtl/hamming_secded_pipe.sv - two-stage Hamming SECDED encoder/decoder with saturating error counters
module hamming_secded_pipe_core #(
   parameter int DATA_WIDTH  = 32,
   parameter int CNT_WIDTH   = 16,
   parameter int ADDR_WIDTH  = 6,
   parameter int CODED_WIDTH = 39
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   hamming_secded_pipe_if.slave    bus,
   input  logic                    clear_counts_i,
   output logic [CNT_WIDTH-1:0]    corr_count_o,
   output logic [CNT_WIDTH-1:0]    uncorr_count_o
);
   function automatic logic [ADDR_WIDTH-1:0] syndrome(input logic [CODED_WIDTH-1:0] cw);
      logic [ADDR_WIDTH-1:0] s;
      s = '0;
      for (int j = 1; j < CODED_WIDTH; j++) begin
         if (cw[j]) s = s ^ ADDR_WIDTH'(j);
      end
      return s;
   endfunction

   // Parity bit i is exactly bit i of the syndrome of the data-only word.
   function automatic logic [CODED_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] data);
      logic [CODED_WIDTH-1:0] cw;
      logic [DATA_WIDTH-1:0]  rest;
      logic [ADDR_WIDTH-1:0]  par;
      cw   = '0;
      rest = data;
      for (int j = 1; j < CODED_WIDTH; j++) begin
         if ((j & (j - 1)) != 0) begin
            cw[j] = rest[0];
            rest  = rest >> 1;
         end
      end
      par = syndrome(cw);
      for (int i = 0; i < ADDR_WIDTH; i++) cw[1 << i] = par[i];
      cw[0] = ^cw[CODED_WIDTH-1:1];
      return cw;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extract(input logic [CODED_WIDTH-1:0] cw);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      for (int j = CODED_WIDTH - 1; j >= 1; j--) begin
         if ((j & (j - 1)) != 0) d = (d << 1) | DATA_WIDTH'(cw[j]);
      end
      return d;
   endfunction

   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_mode_q, s1_mode_d;
   logic [CODED_WIDTH-1:0] s1_data_q, s1_data_d;
   logic [ADDR_WIDTH-1:0]  s1_syn_q, s1_syn_d;
   logic                   s1_ovr_q, s1_ovr_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_mode_q, out_mode_d;
   logic [CODED_WIDTH-1:0] out_data_q, out_data_d;
   logic                   out_single_q, out_single_d;
   logic                   out_double_q, out_double_d;
   logic [ADDR_WIDTH-1:0]  out_syn_q, out_syn_d;
   logic [CNT_WIDTH-1:0]   corr_q, corr_d;
   logic [CNT_WIDTH-1:0]   uncorr_q, uncorr_d;
   logic                   advance;
   logic                   is_single;
   logic                   is_double;
   logic                   dec_done;
   logic [CODED_WIDTH-1:0] fixed;

   always_comb begin
      advance      = !out_valid_q || bus.out_ready;
      s1_valid_d   = s1_valid_q;
      s1_mode_d    = s1_mode_q;
      s1_data_d    = s1_data_q;
      s1_syn_d     = s1_syn_q;
      s1_ovr_d     = s1_ovr_q;
      out_valid_d  = out_valid_q;
      out_mode_d   = out_mode_q;
      out_data_d   = out_data_q;
      out_single_d = out_single_q;
      out_double_d = out_double_q;
      out_syn_d    = out_syn_q;
      is_single    = s1_ovr_q && (int'(s1_syn_q) < CODED_WIDTH);
      is_double    = (!s1_ovr_q && (s1_syn_q != '0)) || (s1_ovr_q && (int'(s1_syn_q) >= CODED_WIDTH));
      fixed        = is_single ? (s1_data_q ^ (CODED_WIDTH'(1) << s1_syn_q)) : s1_data_q;

      if (advance) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_mode_d = bus.mode;
            s1_data_d = bus.in_data;
            s1_syn_d  = syndrome(bus.in_data);
            s1_ovr_d  = ^bus.in_data;
         end
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_mode_d = s1_mode_q;
            if (s1_mode_q) begin
               out_data_d   = CODED_WIDTH'(extract(fixed));
               out_single_d = is_single;
               out_double_d = is_double;
               out_syn_d    = s1_syn_q;
            end else begin
               out_data_d   = encode(s1_data_q[DATA_WIDTH-1:0]);
               out_single_d = 1'b0;
               out_double_d = 1'b0;
               out_syn_d    = '0;
            end
         end
      end

      // Only decode beats actually handed downstream are counted; clear wins.
      dec_done = out_valid_q && bus.out_ready && out_mode_q;
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      if (clear_counts_i) begin
         corr_d   = '0;
         uncorr_d = '0;
      end else begin
         if (dec_done && out_single_q && (corr_q != '1)) corr_d = corr_q + CNT_WIDTH'(1);
         if (dec_done && out_double_q && (uncorr_q != '1)) uncorr_d = uncorr_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q   <= 1'b0;
         s1_mode_q    <= 1'b0;
         s1_data_q    <= '0;
         s1_syn_q     <= '0;
         s1_ovr_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_mode_q   <= 1'b0;
         out_data_q   <= '0;
         out_single_q <= 1'b0;
         out_double_q <= 1'b0;
         out_syn_q    <= '0;
         corr_q       <= '0;
         uncorr_q     <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_mode_q    <= s1_mode_d;
         s1_data_q    <= s1_data_d;
         s1_syn_q     <= s1_syn_d;
         s1_ovr_q     <= s1_ovr_d;
         out_valid_q  <= out_valid_d;
         out_mode_q   <= out_mode_d;
         out_data_q   <= out_data_d;
         out_single_q <= out_single_d;
         out_double_q <= out_double_d;
         out_syn_q    <= out_syn_d;
         corr_q       <= corr_d;
         uncorr_q     <= uncorr_d;
      end
   end

   assign bus.in_ready       = advance;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_mode       = out_mode_q;
   assign bus.out_data       = out_data_q;
   assign bus.out_single_err = out_single_q;
   assign bus.out_double_err = out_double_q;
   assign bus.out_syndrome   = out_syn_q;
   assign corr_count_o       = corr_q;
   assign uncorr_count_o     = uncorr_q;
endmodule

module hamming_secded_pipe #(
   parameter int  DATA_WIDTH  = 32,
   parameter int  CNT_WIDTH   = 16,
   // Smallest P with 2**P >= DATA_WIDTH+P+1, refined from the lower bound clog2(DATA_WIDTH+1).
   localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1),
   localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic                   mode_i,
   input  logic [CODED_WIDTH-1:0] in_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [CODED_WIDTH-1:0] out_data_o,
   output logic                   out_mode_o,
   output logic                   out_single_err_o,
   output logic                   out_double_err_o,
   output logic [ADDR_WIDTH-1:0]  out_syndrome_o,
   input  logic                   clear_counts_i,
   output logic [CNT_WIDTH-1:0]   corr_count_o,
   output logic [CNT_WIDTH-1:0]   uncorr_count_o
);
   hamming_secded_pipe_if #(.CODED_WIDTH(CODED_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   assign bus.in_valid      = in_valid_i;
   assign bus.mode          = mode_i;
   assign bus.in_data       = in_data_i;
   assign bus.out_ready     = out_ready_i;
   assign in_ready_o        = bus.in_ready;
   assign out_valid_o       = bus.out_valid;
   assign out_data_o        = bus.out_data;
   assign out_mode_o        = bus.out_mode;
   assign out_single_err_o  = bus.out_single_err;
   assign out_double_err_o  = bus.out_double_err;
   assign out_syndrome_o    = bus.out_syndrome;

   hamming_secded_pipe_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .CODED_WIDTH(CODED_WIDTH)
   ) u_core (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .bus           (bus),
      .clear_counts_i(clear_counts_i),
      .corr_count_o  (corr_count_o),
      .uncorr_count_o(uncorr_count_o)
   );
endmodule

// File: tb/tb_hamming_secded_pipe.sv
// tb/tb_hamming_secded_pipe.sv - directed bench for hamming_secded_pipe at DATA_WIDTH 4 and 3
module tb_hamming_secded_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear = 1'b0;
   logic [1:0]  corr0, uncorr0;
   logic [15:0] corr1, uncorr1;
   int n_vec = 0;
   int n_mis = 0;

   logic       o_valid, o_mode, o_s, o_d, o_rdy;
   logic [7:0] o_data;
   logic [2:0] o_syn;

   always #5 clk = ~clk;

   hamming_secded_pipe_if #(.CODED_WIDTH(8), .ADDR_WIDTH(3)) bus0 ();
   hamming_secded_pipe_if #(.CODED_WIDTH(7), .ADDR_WIDTH(3)) bus1 ();

   hamming_secded_pipe #(.DATA_WIDTH(4), .CNT_WIDTH(2)) u_dut0 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(bus0.in_valid), .in_ready_o(bus0.in_ready), .mode_i(bus0.mode), .in_data_i(bus0.in_data),
      .out_valid_o(bus0.out_valid), .out_ready_i(bus0.out_ready), .out_data_o(bus0.out_data),
      .out_mode_o(bus0.out_mode), .out_single_err_o(bus0.out_single_err), .out_double_err_o(bus0.out_double_err),
      .out_syndrome_o(bus0.out_syndrome), .clear_counts_i(clear),
      .corr_count_o(corr0), .uncorr_count_o(uncorr0)
   );

   hamming_secded_pipe #(.DATA_WIDTH(3), .CNT_WIDTH(16)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(bus1.in_valid), .in_ready_o(bus1.in_ready), .mode_i(bus1.mode), .in_data_i(bus1.in_data),
      .out_valid_o(bus1.out_valid), .out_ready_i(bus1.out_ready), .out_data_o(bus1.out_data),
      .out_mode_o(bus1.out_mode), .out_single_err_o(bus1.out_single_err), .out_double_err_o(bus1.out_double_err),
      .out_syndrome_o(bus1.out_syndrome), .clear_counts_i(clear),
      .corr_count_o(corr1), .uncorr_count_o(uncorr1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_mis++;
         $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
         $error("miscompare at %s", tag);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int sel, input logic v, input logic m, input logic [7:0] d);
      if (sel == 0) begin
         bus0.in_valid = v; bus0.mode = m; bus0.in_data = d;
      end else begin
         bus1.in_valid = v; bus1.mode = m; bus1.in_data = d[6:0];
      end
   endtask

   task automatic get(input int sel);
      if (sel == 0) begin
         o_valid = bus0.out_valid; o_mode = bus0.out_mode; o_data = bus0.out_data;
         o_s = bus0.out_single_err; o_d = bus0.out_double_err; o_syn = bus0.out_syndrome; o_rdy = bus0.in_ready;
      end else begin
         o_valid = bus1.out_valid; o_mode = bus1.out_mode; o_data = {1'b0, bus1.out_data};
         o_s = bus1.out_single_err; o_d = bus1.out_double_err; o_syn = bus1.out_syndrome; o_rdy = bus1.in_ready;
      end
   endtask

   task automatic check_beat(input string tag, input int sel, input logic m, input logic [7:0] ed,
                             input logic es, input logic edd, input logic [2:0] esyn);
      get(sel);
      chk($sformatf("%s.valid", tag), o_valid, 1);
      chk($sformatf("%s.mode", tag), o_mode, m);
      chk($sformatf("%s.data", tag), o_data, ed);
      chk($sformatf("%s.single", tag), o_s, es);
      chk($sformatf("%s.double", tag), o_d, edd);
      chk($sformatf("%s.syn", tag), o_syn, esyn);
   endtask

   task automatic run1(input string tag, input int sel, input logic m, input logic [7:0] din,
                       input logic [7:0] ed, input logic es, input logic edd, input logic [2:0] esyn);
      drive(sel, 1'b1, m, din);
      step();
      drive(sel, 1'b0, 1'b0, 8'h00);
      get(sel);
      chk($sformatf("%s.lat1", tag), o_valid, 0);
      step();
      check_beat(tag, sel, m, ed, es, edd, esyn);
      step();
      get(sel);
      chk($sformatf("%s.drain", tag), o_valid, 0);
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00);
      bus0.out_ready = 1'b0;
      bus1.out_ready = 1'b1;
      step();
      step();
      get(0);
      chk("rst.valid", o_valid, 0);
      chk("rst.data", o_data, 0);
      chk("rst.mode", o_mode, 0);
      chk("rst.flags", {o_s, o_d}, 0);
      chk("rst.syn", o_syn, 0);
      chk("rst.counts", {corr0, uncorr0}, 0);
      rst = 1'b0;
      step();
      get(0);
      chk("rst.in_ready", o_rdy, 1);
      bus0.out_ready = 1'b1;

      run1("enc0B", 0, 1'b0, 8'h0B, 8'hAA, 0, 0, 3'd0);
      run1("encFB", 0, 1'b0, 8'hFB, 8'hAA, 0, 0, 3'd0);
      run1("enc00", 0, 1'b0, 8'h00, 8'h00, 0, 0, 3'd0);
      run1("enc0F", 0, 1'b0, 8'h0F, 8'hFF, 0, 0, 3'd0);
      run1("decAA", 0, 1'b1, 8'hAA, 8'h0B, 0, 0, 3'd0);
      run1("dec8A", 0, 1'b1, 8'h8A, 8'h0B, 1, 0, 3'd5);
      run1("decAB", 0, 1'b1, 8'hAB, 8'h0B, 1, 0, 3'd0);
      chk("cnt.corr2", corr0, 2);
      chk("cnt.uncorr0", uncorr0, 0);
      run1("dec8B", 0, 1'b1, 8'h8B, 8'h09, 0, 1, 3'd5);
      chk("cnt.uncorr1", uncorr0, 1);
      chk("cnt.corr_keep", corr0, 2);

      // Stall: A=enc 01, B=dec 8A, C=dec 8B, D=enc 0B with out_ready low for three edges.
      drive(0, 1'b1, 1'b0, 8'h01);
      step();
      drive(0, 1'b1, 1'b1, 8'h8A);
      step();
      check_beat("stA", 0, 1'b0, 8'h0F, 0, 0, 3'd0);
      bus0.out_ready = 1'b0;
      drive(0, 1'b1, 1'b1, 8'h8B);
      for (int i = 0; i < 3; i++) begin
         step();
         check_beat($sformatf("hold%0d", i), 0, 1'b0, 8'h0F, 0, 0, 3'd0);
         chk($sformatf("hold%0d.in_ready", i), o_rdy, 0);
      end
      bus0.out_ready = 1'b1;
      step();
      check_beat("stB", 0, 1'b1, 8'h0B, 1, 0, 3'd5);
      drive(0, 1'b1, 1'b0, 8'h0B);
      step();
      check_beat("stC", 0, 1'b1, 8'h09, 0, 1, 3'd5);
      drive(0, 1'b0, 1'b0, 8'h00);
      step();
      check_beat("stD", 0, 1'b0, 8'hAA, 0, 0, 3'd0);
      step();
      get(0);
      chk("st.drain", o_valid, 0);
      chk("st.corr", corr0, 3);
      chk("st.uncorr", uncorr0, 2);

      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr.counts", {corr0, uncorr0}, 0);

      // Five single-error decodes back to back: one beat per cycle and the 2-bit counter saturates.
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b1, 1'b1, 8'hAB);
         step();
         get(0);
         if (i >= 1) chk($sformatf("tput%0d", i), o_valid, 1);
      end
      drive(0, 1'b0, 1'b0, 8'h00);
      step();
      get(0);
      chk("tput5", o_valid, 1);
      step();
      get(0);
      chk("tput.drain", o_valid, 0);
      chk("sat.corr", corr0, 3);

      drive(0, 1'b1, 1'b1, 8'hAB);
      step();
      drive(0, 1'b0, 1'b0, 8'h00);
      step();
      check_beat("sixth", 0, 1'b1, 8'h0B, 1, 0, 3'd0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr.prio", corr0, 0);
      step();
      chk("clr.after", corr0, 0);

      run1("w3.enc5", 1, 1'b0, 8'h05, 8'h5A, 0, 0, 3'd0);
      run1("w3.dec5A", 1, 1'b1, 8'h5A, 8'h05, 0, 0, 3'd0);
      run1("w3.syn7", 1, 1'b1, 8'h16, 8'h00, 0, 1, 3'd7);
      run1("w3.dec1A", 1, 1'b1, 8'h1A, 8'h05, 1, 0, 3'd6);
      chk("w3.corr", corr1, 1);
      chk("w3.uncorr", uncorr1, 1);

      // Reset with two beats in flight must discard both.
      drive(1, 1'b1, 1'b1, 8'h1A);
      step();
      drive(1, 1'b1, 1'b1, 8'h16);
      step();
      get(1);
      chk("fly.valid", o_valid, 1);
      rst = 1'b1;
      drive(1, 1'b0, 1'b0, 8'h00);
      step();
      get(1);
      chk("fly.rst_valid", o_valid, 0);
      chk("fly.rst_counts", {corr1, uncorr1}, 0);
      rst = 1'b0;
      step();
      get(1);
      chk("fly.discard", o_valid, 0);
      chk("fly.in_ready", o_rdy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule

// File: doc/hamming_secded_pipe.md
HAMMING_SECDED_PIPE -- requirements
Module: hamming_secded_pipe

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the payload width (>=1).
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, giving the error-counter width (>=1).
REQ-003 The module SHALL have derived localparam ADDR_WIDTH: the smallest P with 2**P >= DATA_WIDTH+P+1; CODED_WIDTH = DATA_WIDTH+ADDR_WIDTH+1.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port in_valid_i, input, 1 bit: the input beat is valid.
REQ-007 The module SHALL have port in_ready_o, output, 1 bit: the block accepts an input beat this cycle.
REQ-008 The module SHALL have port mode_i, input, 1 bit: 0 = encode, 1 = decode; sampled with the beat.
REQ-009 The module SHALL have port in_data_i, input, CODED_WIDTH bits: encode uses [DATA_WIDTH-1:0]; decode uses the full codeword.
REQ-010 The module SHALL have port out_valid_o, output, 1 bit: the output beat is valid.
REQ-011 The module SHALL have port out_ready_i, input, 1 bit: downstream accepts the output beat.
REQ-012 The module SHALL have port out_data_o, output, CODED_WIDTH bits: the codeword (encode) or the corrected data zero-extended (decode).
REQ-013 The module SHALL have port out_mode_o, output, 1 bit: the mode of the current output beat.
REQ-014 The module SHALL have port out_single_err_o, output, 1 bit: a corrected single-bit error (decode only).
REQ-015 The module SHALL have port out_double_err_o, output, 1 bit: an uncorrectable error (decode only).
REQ-016 The module SHALL have port out_syndrome_o, output, ADDR_WIDTH bits: the raw syndrome (decode; 0 in encode).
REQ-017 The module SHALL have port clear_counts_i, input, 1 bit: synchronous clear of both counters.
REQ-018 The module SHALL have port corr_count_o, output, CNT_WIDTH bits: the saturating count of corrected beats.
REQ-019 The module SHALL have port uncorr_count_o, output, CNT_WIDTH bits: the saturating count of uncorrectable beats.

Function
REQ-020 The codeword layout SHALL be: bit 0 = overall parity of bits [CODED_WIDTH-1:1]; bits 2**i (i<ADDR_WIDTH) = Hamming parity; data bits fill the remaining positions ascending, data bit 0 at the lowest free position.
REQ-021 Hamming parity bit i SHALL equal the XOR of all data-position bits whose index has bit i set.
REQ-022 The syndrome SHALL be the XOR of the indices of all set bits in positions 1..CODED_WIDTH-1; overall parity SHALL be the XOR of bits 0..CODED_WIDTH-1.
REQ-023 Decode classification SHALL be: syn=0 and ovr=0 -> clean; ovr=1 and syn<CODED_WIDTH -> single error, flip bit syn (syn=0 flips bit 0); ovr=0 and syn!=0 -> double error; ovr=1 and syn>=CODED_WIDTH -> double error.
REQ-024 On a double error, the data SHALL be extracted uncorrected and out_single_err_o SHALL be 0.
REQ-025 The block SHALL be a two-stage pipeline: stage 1 registers the beat, mode, syndrome and parity; stage 2 registers the correction, extraction and flags.
REQ-026 Latency SHALL be 2 cycles from an accepted input to out_valid_o, when not stalled.
REQ-027 The handshake SHALL use advance = !out_valid_o || out_ready_i and in_ready_o = advance, with a transfer when valid && ready on each side.
REQ-028 The pipeline SHALL hold all stage registers when advance=0; no beat is dropped or duplicated, and out_data_o, out_mode_o and the flags are stable while out_valid_o=1 and out_ready_i=0.
REQ-029 The pipeline SHALL sustain one beat per cycle with out_ready_i held at 1.
REQ-030 Encode beats SHALL drive out_single_err_o, out_double_err_o and out_syndrome_o to 0.
REQ-031 Counters SHALL increment only on an output transfer of a decode beat with the matching flag, and saturate at all-ones.
REQ-032 clear_counts_i SHALL take priority over an increment in the same cycle, with a result of 0.
REQ-033 Mixed encode/decode beats back-to-back SHALL each be processed per their own sampled mode.

Reset
REQ-034 When rst_i=1 at a clk_i edge, both stage valids, out_valid_o, the flags, out_syndrome_o, out_data_o, out_mode_o and both counters SHALL be 0.
REQ-035 In-flight beats SHALL be discarded on reset.
REQ-036 in_ready_o SHALL be 1 in the first cycle after reset deasserts.

Verification (DATA_WIDTH=4: ADDR_WIDTH=3, CODED_WIDTH=8, data at bits 3,5,6,7)
REQ-037 Encode in_data_i=0x0B -> out_data_o=0xAA two cycles later, with all flags 0.
REQ-038 Decode 0xAA -> data 0x0B, clean; decode 0x8A -> 0x0B, single=1, syndrome=5; decode 0xAB -> 0x0B, single=1, syndrome=0.
REQ-039 Decode 0x8B -> double=1, syndrome=5, single=0, uncorr_count_o increments by 1.
REQ-040 Four back-to-back beats with out_ready_i low for 3 cycles mid-stream -> all four emerge in order, output held stable during the stall, in_ready_o=0 while stalled.
REQ-041 CNT_WIDTH=2 with five single-error decodes -> corr_count_o saturates at 3; clear_counts_i coincident with a sixth error -> 0.
REQ-042 DATA_WIDTH=3 (CODED_WIDTH=7) with input yielding syndrome 7 and ovr=1 -> double=1; rst_i asserted with beats in flight -> out_valid_o=0 next cycle and counters=0.
